// File: rtl/apb_uart_fifo_top_if.sv
// APB3 bus bundle for apb_uart_fifo_top.
// Signals: PSELx, PENABLE, PWRITE, PADDR, PWDATA (master -> slave);
//          PRDATA, PREADY, PSLVERR (slave -> master).
// Modports: master (bus driver / testbench), slave (peripheral).
interface apb_uart_fifo_top_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  PSELx;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_uart_fifo_top.sv
// APB3 UART peripheral with TX/RX FIFOs, programmable baud divisor,
// optional even/odd parity, 1/2 TX stop bits, sticky error flags, level irq.
// Ports:
//   PCLK    clock, rising edge
//   PRESET  synchronous active-high reset
//   apb     APB3 slave bundle (zero wait states)
//   RX      asynchronous serial input, idle high
//   Tx      serial output, idle high (registered)
//   irq     level interrupt
// Register map (PADDR[4:2]): 0 TXDATA, 1 RXDATA, 2 STATUS, 3 CTRL, 4 BAUDDIV.
//
// TX / RX FSM states:
//   state    | meaning
//   S_IDLE   | line idle, waiting for work (TX: FIFO data, RX: falling edge)
//   S_START  | start bit (RX: half-bit wait then false-start check)
//   S_DATA   | 8 data bits, LSB first
//   S_PARITY | parity bit, only when parity was enabled at frame start
//   S_STOP   | stop bit(s); TX chains straight into the next frame
module apb_uart_fifo_top #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 867
) (
  input  logic               PCLK,
  input  logic               PRESET,
  apb_uart_fifo_top_if.slave apb,
  input  logic               RX,
  output logic               Tx,
  output logic               irq
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic                 access, wr_acc, rd_acc;
  logic [2:0]           addr;
  logic [7:0]           ctrl;
  logic [DIV_WIDTH-1:0] bauddiv;
  logic                 overrun, parity_err, frame_err;

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wp, tx_rp;
  logic [CW-1:0] tx_cnt;
  logic          tx_full, tx_empty, tx_push, tx_pop;

  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wp, rx_rp;
  logic [CW-1:0] rx_cnt;
  logic          rx_full, rx_empty, rx_push, rx_pop;

  state_t               tx_state;
  logic [DIV_WIDTH-1:0] tx_tmr, tx_div;
  logic [2:0]           tx_bit;
  logic [7:0]           tx_data;
  logic                 tx_par_en, tx_par_odd, tx_stop2, tx_second, tx_frame_end, tx_busy;

  state_t               rx_state;
  logic [DIV_WIDTH-1:0] rx_tmr, rx_div, rx_half_load;
  logic [DIV_WIDTH:0]   rx_half_p1;
  logic [2:0]           rx_bit;
  logic [7:0]           rx_data;
  logic                 rx_s1, rx_s2, rx_prev, rx_par_en, rx_par_odd, rx_par_ok;
  logic                 rx_stop_smp, rx_good, ovr_set, par_set, frm_set, sts_w1c;

  logic [15:0]           status;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;
  logic                  unused_bits;

  assign access = apb.PSELx & apb.PENABLE;
  assign wr_acc = access & apb.PWRITE;
  assign rd_acc = access & ~apb.PWRITE;
  assign addr   = apb.PADDR[4:2];
  assign unused_bits = ^{apb.PWDATA, apb.PADDR};

  assign tx_full  = (tx_cnt == CW'(FIFO_DEPTH));
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == CW'(FIFO_DEPTH));
  assign rx_empty = (rx_cnt == '0);
  assign tx_busy  = (tx_state != S_IDLE);

  // Last cycle of the final stop bit; a pop here starts the next frame with no gap.
  assign tx_frame_end = (tx_state == S_STOP) && (tx_tmr == '0) && !(tx_stop2 && !tx_second);
  assign tx_push = wr_acc && (addr == 3'd0) && !tx_full;
  assign tx_pop  = ctrl[0] && !tx_empty && ((tx_state == S_IDLE) || tx_frame_end);

  assign rx_stop_smp = (rx_state == S_STOP) && (rx_tmr == '0);
  assign rx_good = rx_s2 && rx_par_ok;
  assign rx_push = rx_stop_smp && rx_good && !rx_full;
  assign ovr_set = rx_stop_smp && rx_good && rx_full;
  assign par_set = rx_stop_smp && rx_s2 && !rx_par_ok;
  assign frm_set = rx_stop_smp && !rx_s2;
  assign rx_pop  = rd_acc && (addr == 3'd1) && !rx_empty;
  assign sts_w1c = wr_acc && (addr == 3'd2);

  // First sample lands (BAUDDIV+1)/2 cycles after the detected falling edge.
  assign rx_half_p1   = ({1'b0, bauddiv} + {{DIV_WIDTH{1'b0}}, 1'b1}) >> 1;
  assign rx_half_load = (rx_half_p1 == '0) ? '0
                      : DIV_WIDTH'(rx_half_p1 - {{DIV_WIDTH{1'b0}}, 1'b1});

  assign status = {8'(rx_cnt), tx_busy, frame_err, parity_err, overrun,
                   rx_empty, rx_full, tx_empty, tx_full};

  assign irq = (ctrl[5] & ~rx_empty) | (ctrl[6] & tx_empty) |
               (ctrl[7] & (overrun | parity_err | frame_err));

  always_comb begin
    prdata  = '0;
    pslverr = 1'b0;
    if (access) begin
      case (addr)
        3'd0: pslverr = ~apb.PWRITE | tx_full;
        3'd1: begin
          if (apb.PWRITE || rx_empty) pslverr = 1'b1;
          else                        prdata  = DATA_WIDTH'(rx_mem[rx_rp]);
        end
        3'd2: if (!apb.PWRITE) prdata = DATA_WIDTH'(status);
        3'd3: if (!apb.PWRITE) prdata = DATA_WIDTH'(ctrl);
        3'd4: if (!apb.PWRITE) prdata = DATA_WIDTH'(bauddiv);
        default: pslverr = 1'b1;
      endcase
    end
  end

  assign apb.PRDATA  = prdata;
  assign apb.PSLVERR = pslverr;
  assign apb.PREADY  = 1'b1;

  always_ff @(posedge PCLK) begin
    if (tx_push) tx_mem[tx_wp] <= apb.PWDATA[7:0];
    if (rx_push) rx_mem[rx_wp] <= rx_data;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ctrl       <= '0;
      bauddiv    <= DIV_WIDTH'(DEFAULT_DIV);
      overrun    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      tx_wp      <= '0;
      tx_rp      <= '0;
      tx_cnt     <= '0;
      rx_wp      <= '0;
      rx_rp      <= '0;
      rx_cnt     <= '0;
    end else begin
      if (wr_acc && addr == 3'd3) ctrl    <= apb.PWDATA[7:0];
      if (wr_acc && addr == 3'd4) bauddiv <= apb.PWDATA[DIV_WIDTH-1:0];
      // set has priority over write-1-clear
      overrun    <= (overrun    & ~(sts_w1c & apb.PWDATA[4])) | ovr_set;
      parity_err <= (parity_err & ~(sts_w1c & apb.PWDATA[5])) | par_set;
      frame_err  <= (frame_err  & ~(sts_w1c & apb.PWDATA[6])) | frm_set;
      if (tx_push) tx_wp <= tx_wp + PW'(1);
      if (tx_pop)  tx_rp <= tx_rp + PW'(1);
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
      if (rx_push) rx_wp <= rx_wp + PW'(1);
      if (rx_pop)  rx_rp <= rx_rp + PW'(1);
      rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tx_state   <= S_IDLE;
      Tx         <= 1'b1;
      tx_tmr     <= '0;
      tx_div     <= '0;
      tx_bit     <= '0;
      tx_data    <= '0;
      tx_par_en  <= 1'b0;
      tx_par_odd <= 1'b0;
      tx_stop2   <= 1'b0;
      tx_second  <= 1'b0;
    end else if (tx_pop) begin
      // frame settings are frozen here so register writes only affect the next frame
      tx_state   <= S_START;
      Tx         <= 1'b0;
      tx_data    <= tx_mem[tx_rp];
      tx_div     <= bauddiv;
      tx_tmr     <= bauddiv;
      tx_par_en  <= ctrl[2];
      tx_par_odd <= ctrl[3];
      tx_stop2   <= ctrl[4];
      tx_second  <= 1'b0;
    end else begin
      case (tx_state)
        S_IDLE: Tx <= 1'b1;
        S_START: begin
          if (tx_tmr == '0) begin
            tx_state <= S_DATA;
            Tx       <= tx_data[0];
            tx_bit   <= '0;
            tx_tmr   <= tx_div;
          end else tx_tmr <= tx_tmr - DIV_WIDTH'(1);
        end
        S_DATA: begin
          if (tx_tmr == '0) begin
            tx_tmr <= tx_div;
            if (tx_bit == 3'd7) begin
              if (tx_par_en) begin
                tx_state <= S_PARITY;
                Tx       <= ^tx_data ^ tx_par_odd;
              end else begin
                tx_state <= S_STOP;
                Tx       <= 1'b1;
              end
            end else begin
              tx_bit <= tx_bit + 3'd1;
              Tx     <= tx_data[tx_bit + 3'd1];
            end
          end else tx_tmr <= tx_tmr - DIV_WIDTH'(1);
        end
        S_PARITY: begin
          if (tx_tmr == '0) begin
            tx_state <= S_STOP;
            Tx       <= 1'b1;
            tx_tmr   <= tx_div;
          end else tx_tmr <= tx_tmr - DIV_WIDTH'(1);
        end
        S_STOP: begin
          if (tx_tmr == '0) begin
            if (tx_stop2 && !tx_second) begin
              tx_second <= 1'b1;
              tx_tmr    <= tx_div;
            end else tx_state <= S_IDLE;
          end else tx_tmr <= tx_tmr - DIV_WIDTH'(1);
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state   <= S_IDLE;
      rx_tmr     <= '0;
      rx_div     <= '0;
      rx_bit     <= '0;
      rx_data    <= '0;
      rx_par_en  <= 1'b0;
      rx_par_odd <= 1'b0;
      rx_par_ok  <= 1'b1;
    end else begin
      rx_s1   <= RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_state)
        S_IDLE: begin
          if (ctrl[1] && rx_prev && !rx_s2) begin
            rx_state   <= S_START;
            rx_tmr     <= rx_half_load;
            rx_div     <= bauddiv;
            rx_par_en  <= ctrl[2];
            rx_par_odd <= ctrl[3];
            rx_par_ok  <= 1'b1;
          end
        end
        S_START: begin
          if (rx_tmr == '0) begin
            if (rx_s2) rx_state <= S_IDLE;
            else begin
              rx_state <= S_DATA;
              rx_bit   <= '0;
              rx_tmr   <= rx_div;
            end
          end else rx_tmr <= rx_tmr - DIV_WIDTH'(1);
        end
        S_DATA: begin
          if (rx_tmr == '0) begin
            rx_data[rx_bit] <= rx_s2;
            rx_tmr          <= rx_div;
            if (rx_bit == 3'd7) rx_state <= rx_par_en ? S_PARITY : S_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else rx_tmr <= rx_tmr - DIV_WIDTH'(1);
        end
        S_PARITY: begin
          if (rx_tmr == '0) begin
            rx_par_ok <= (rx_s2 == (^rx_data ^ rx_par_odd));
            rx_state  <= S_STOP;
            rx_tmr    <= rx_div;
          end else rx_tmr <= rx_tmr - DIV_WIDTH'(1);
        end
        S_STOP: begin
          if (rx_tmr == '0) rx_state <= S_IDLE;
          else              rx_tmr   <= rx_tmr - DIV_WIDTH'(1);
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_uart_fifo_top.sv
// Directed testbench for apb_uart_fifo_top with TX/RX byte scoreboards.
module tb_apb_uart_fifo_top;
  localparam int P = 4;  // bit period with BAUDDIV = 3

  logic PCLK = 1'b0;
  logic PRESET;
  logic rx_drv, loop_en;
  logic RX, Tx, irq;

  always #5 PCLK = ~PCLK;

  apb_uart_fifo_top_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

  assign RX = loop_en ? Tx : rx_drv;

  apb_uart_fifo_top #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .FIFO_DEPTH(8), .DIV_WIDTH(16), .DEFAULT_DIV(867)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .apb(bus), .RX(RX), .Tx(Tx), .irq(irq)
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_wr(input logic [7:0] a, input logic [31:0] d, output logic err);
    @(negedge PCLK);
    bus.PSELx = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = a; bus.PWDATA = d;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    #1 err = bus.PSLVERR;
    @(posedge PCLK);
    #1 bus.PSELx = 1'b0; bus.PENABLE = 1'b0;
  endtask

  task automatic apb_rd(input logic [7:0] a, output logic [31:0] d, output logic err);
    @(negedge PCLK);
    bus.PSELx = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = a; bus.PWDATA = '0;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    #1 d = bus.PRDATA; err = bus.PSLVERR;
    @(posedge PCLK);
    #1 bus.PSELx = 1'b0; bus.PENABLE = 1'b0;
  endtask

  task automatic wait_status(input logic [31:0] mask, input logic [31:0] val,
                             input int budget, output bit ok);
    logic [31:0] d;
    logic e;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      apb_rd(8'h08, d, e);
      if ((d & mask) == val) ok = 1'b1;
    end
  endtask

  // Tx sampled once per cycle on the falling clock edge; index 0 is the first low sample.
  task automatic capture(input int n, output logic [127:0] w, output bit ok);
    w  = '0;
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge PCLK);
      if (Tx === 1'b0) ok = 1'b1;
    end
    w[0] = Tx;
    for (int i = 1; i < n; i++) begin
      @(negedge PCLK);
      w[i] = Tx;
    end
  endtask

  function automatic logic [127:0] wave_of(input logic [7:0] d, input bit par_en,
                                           input bit par_odd, input int off,
                                           input logic [127:0] base);
    logic [10:0] bits;
    int nb;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (par_en) begin
      bits[9] = ^d ^ par_odd;
      nb = 11;
    end else nb = 10;
    for (int b = 0; b < nb; b++)
      for (int c = 0; c < P; c++)
        base[off + b*P + c] = bits[b];
    return base;
  endfunction

  task automatic send_rx(input logic [7:0] b, input logic stop_b);
    logic [9:0] f;
    f = {stop_b, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge PCLK);
      rx_drv = f[i];
      repeat (P-1) @(negedge PCLK);
    end
    @(negedge PCLK);
    rx_drv = 1'b1;
    repeat (3) @(negedge PCLK);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]  d;
    logic         e;
    bit           ok;
    logic [127:0] w, exp;
    logic [7:0]   b;

    bus.PSELx = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = '0; bus.PWDATA = '0;
    rx_drv = 1'b1; loop_en = 1'b0;
    PRESET = 1'b1;
    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;

    // reset state
    #1;
    check("rst_tx", Tx, 1'b1);
    check("rst_irq", irq, 1'b0);
    check("rst_prdata_idle", bus.PRDATA, 32'h0);
    check("rst_pslverr_idle", bus.PSLVERR, 1'b0);
    check("rst_pready", bus.PREADY, 1'b1);
    apb_rd(8'h08, d, e); check("rst_status", d, 32'h0000_000A);
    apb_rd(8'h0C, d, e); check("rst_ctrl", d, 32'h0);
    apb_rd(8'h10, d, e); check("rst_bauddiv", d, 32'd867);

    // 1: single 8N1 frame, 4 cycles per bit
    apb_wr(8'h10, 32'd3, e);
    apb_wr(8'h0C, 32'h01, e);
    apb_wr(8'h00, 32'hA5, e); tx_q.push_back(8'hA5);
    check("t1_push_err", e, 1'b0);
    capture(40, w, ok);
    check("t1_start_seen", ok, 1'b1);
    exp = wave_of(tx_q.pop_front(), 1'b0, 1'b0, 0, '0);
    check("t1_wave", w, exp);
    apb_rd(8'h08, d, e); check("t1_status_idle", d, 32'h0000_000A);

    // 2: even parity, two back-to-back frames
    apb_wr(8'h0C, 32'h06, e);
    apb_wr(8'h00, 32'h03, e); tx_q.push_back(8'h03);
    apb_wr(8'h00, 32'h80, e); tx_q.push_back(8'h80);
    apb_wr(8'h0C, 32'h07, e);
    capture(88, w, ok);
    check("t2_start_seen", ok, 1'b1);
    exp = wave_of(tx_q.pop_front(), 1'b1, 1'b0, 0, '0);
    exp = wave_of(tx_q.pop_front(), 1'b1, 1'b0, 11*P, exp);
    check("t2_wave", w, exp);
    check("t2_parity0", w[9*P + 2], 1'b0);
    check("t2_parity1", w[11*P + 9*P + 2], 1'b1);
    wait_status(32'h82, 32'h02, 100, ok);
    check("t2_tx_idle_wait", ok, 1'b1);

    // 3: loopback
    loop_en = 1'b1;
    apb_wr(8'h0C, 32'h03, e);
    apb_wr(8'h00, 32'h5A, e); rx_q.push_back(8'h5A);
    wait_status(32'h08, 32'h00, 200, ok);
    check("t3_rx_wait", ok, 1'b1);
    apb_rd(8'h04, d, e);
    check("t3_rxdata", d, {24'h0, rx_q.pop_front()});
    check("t3_rxdata_err", e, 1'b0);
    apb_rd(8'h08, d, e); check("t3_rx_empty", d[3], 1'b1);
    apb_rd(8'h04, d, e);
    check("t3_empty_err", e, 1'b1);
    check("t3_empty_data", d, 32'h0);

    // 4: TX FIFO overflow with transmitter disabled, then drain through loopback
    apb_wr(8'h0C, 32'h00, e);
    for (int i = 0; i < 9; i++) begin
      b = 8'h30 + 8'(i * 7);
      apb_wr(8'h00, {24'h0, b}, e);
      if (i < 8) rx_q.push_back(b);
      check($sformatf("t4_push_err_%0d", i), e, (i == 8));
    end
    apb_rd(8'h08, d, e); check("t4_status_full", d, 32'h0000_0009);
    apb_rd(8'h1C, d, e); check("t4_unmapped_err", e, 1'b1);
    apb_rd(8'h00, d, e); check("t4_txdata_rd_err", e, 1'b1);
    apb_wr(8'h04, 32'h11, e); check("t4_rxdata_wr_err", e, 1'b1);
    apb_wr(8'h0C, 32'h03, e);
    wait_status(32'hFF82, 32'h0802, 400, ok);
    check("t4_drain_wait", ok, 1'b1);
    apb_rd(8'h08, d, e); check("t4_status_rxfull", d, 32'h0000_0806);
    while (rx_q.size() > 0) begin
      apb_rd(8'h04, d, e);
      check("t4_rxdata", d, {24'h0, rx_q.pop_front()});
    end
    loop_en = 1'b0;

    // 5: RX overrun with error interrupt
    apb_wr(8'h0C, 32'h82, e);
    for (int i = 0; i < 8; i++) begin
      b = 8'(i * 37 + 5);
      rx_q.push_back(b);
      send_rx(b, 1'b1);
    end
    repeat (4) @(negedge PCLK);
    check("t5_irq_before", irq, 1'b0);
    apb_rd(8'h08, d, e); check("t5_status_8", d, 32'h0000_0806);
    send_rx(8'hEE, 1'b1);
    repeat (4) @(negedge PCLK);
    apb_rd(8'h08, d, e); check("t5_status_ovr", d, 32'h0000_0816);
    check("t5_irq_ovr", irq, 1'b1);
    apb_wr(8'h08, 32'h10, e);
    apb_rd(8'h08, d, e); check("t5_status_w1c", d, 32'h0000_0806);
    check("t5_irq_cleared", irq, 1'b0);
    while (rx_q.size() > 0) begin
      apb_rd(8'h04, d, e);
      check("t5_rxdata", d, {24'h0, rx_q.pop_front()});
    end

    // 6: framing error, short glitch, then a good frame
    apb_wr(8'h0C, 32'h02, e);
    send_rx(8'hFF, 1'b0);
    repeat (4) @(negedge PCLK);
    apb_rd(8'h08, d, e); check("t6_frame_err", d, 32'h0000_004A);
    apb_wr(8'h08, 32'h40, e);
    apb_rd(8'h08, d, e); check("t6_frame_w1c", d, 32'h0000_000A);
    @(negedge PCLK); rx_drv = 1'b0;
    @(negedge PCLK); rx_drv = 1'b1;
    repeat (40) @(negedge PCLK);
    apb_rd(8'h08, d, e); check("t6_glitch", d, 32'h0000_000A);
    rx_q.push_back(8'h3C);
    send_rx(8'h3C, 1'b1);
    repeat (4) @(negedge PCLK);
    apb_rd(8'h04, d, e); check("t6_rxdata", d, {24'h0, rx_q.pop_front()});

    // 7: reset in the middle of a TX frame
    apb_wr(8'h0C, 32'h01, e);
    apb_wr(8'h00, 32'h00, e);
    repeat (10) @(negedge PCLK);
    check("t7_midframe_low", Tx, 1'b0);
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    check("t7_reset_tx", Tx, 1'b1);
    @(negedge PCLK); PRESET = 1'b0;
    apb_rd(8'h08, d, e); check("t7_status", d, 32'h0000_000A);
    apb_rd(8'h10, d, e); check("t7_bauddiv", d, 32'd867);
    repeat (20) @(negedge PCLK);
    check("t7_tx_idle", Tx, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
